// File: rtl/connect4_pkg.sv
// Shared constants and types for the Connect-4 / Pop-Out turn controller.
package connect4_pkg;
  localparam int COLS    = 7;
  localparam int ROWS    = 6;
  localparam int WIN_LEN = 4;
  localparam int SCORE_W = 4;

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int HW = $clog2(ROWS + 1);

  localparam logic PLAYER_RED = 1'b1;
  localparam logic PLAYER_YEL = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE, S_DROP, S_SHIFT, S_CLRTOP, S_SCAN, S_RESOLVE, S_OVER
  } state_t;

  typedef struct packed {
    logic occ;
    logic color;
  } cell_t;
endpackage

// File: rtl/connect4_if.sv
// Keypad move handshake, display read port and game status bundle.
interface connect4_if;
  import connect4_pkg::*;

  logic               reset_score;
  logic               move_req;
  logic [CW-1:0]      move_col;
  logic               move_pop;
  logic               move_ack;
  logic               move_err;
  logic               busy;
  logic [CW-1:0]      rd_col;
  logic [RW-1:0]      rd_row;
  logic               rd_occupied;
  logic               rd_color;
  logic               player;
  logic               game_over;
  logic               winner_valid;
  logic               winner;
  logic               draw;
  logic [SCORE_W-1:0] score_red;
  logic [SCORE_W-1:0] score_yel;

  modport master (
    output reset_score, move_req, move_col, move_pop, rd_col, rd_row,
    input  move_ack, move_err, busy, rd_occupied, rd_color, player,
           game_over, winner_valid, winner, draw, score_red, score_yel
  );

  modport slave (
    input  reset_score, move_req, move_col, move_pop, rd_col, rd_row,
    output move_ack, move_err, busy, rd_occupied, rd_color, player,
           game_over, winner_valid, winner, draw, score_red, score_yel
  );
endinterface

// File: rtl/connect4_win_scan.sv
// Combinational check for WIN_LEN-long runs starting at one cell in four directions.
module connect4_win_scan
  import connect4_pkg::*;
(
  input  cell_t [COLS-1:0][ROWS-1:0] board,
  input  logic [CW-1:0]              col,
  input  logic [RW-1:0]              row,
  output logic                       red_hit,
  output logic                       yel_hit
);
  // right, up, up-right, down-right
  localparam int DC [4] = '{1, 0, 1,  1};
  localparam int DR [4] = '{0, 1, 1, -1};

  logic [3:0] run_ok;
  cell_t      start;
  int         c, r;

  always_comb begin
    start  = board[col][row];
    run_ok = '1;
    c      = 0;
    r      = 0;
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < WIN_LEN; k++) begin
        c = int'(col) + k * DC[d];
        r = int'(row) + k * DR[d];
        if (c < 0 || c >= COLS || r < 0 || r >= ROWS) run_ok[d] = 1'b0;
        else if (board[c[CW-1:0]][r[RW-1:0]] != start) run_ok[d] = 1'b0;
      end
    end
    red_hit = start.occ && (start.color == PLAYER_RED) && (|run_ok);
    yel_hit = start.occ && (start.color == PLAYER_YEL) && (|run_ok);
  end
endmodule

// File: rtl/connect4_turn_ctrl.sv
// Connect-4 / Pop-Out game sequencer: move validation, apply, sequential win scan, turn change.
// Define SCORE_EN to enable the saturating per-colour win counters.
module connect4_turn_ctrl
  import connect4_pkg::*;
(
  input logic       clock,
  input logic       reset,
  connect4_if.slave bus
);
  state_t                    state, state_nxt;
  cell_t [COLS-1:0][ROWS-1:0] board;
  logic [HW-1:0]             height [COLS];
  logic [CW-1:0]             cur_col;
  logic [HW-1:0]             sh_row;
  logic [CW-1:0]             scan_col;
  logic [RW-1:0]             scan_row;
  logic                      win_red, win_yel, red_hit, yel_hit;
  logic                      player, move_err, winner_valid, winner, draw;
  logic                      col_ok, bad, accept, all_full, scan_last;
  logic                      mover_win, opp_win;
  logic [HW-1:0]             sel_h;
  cell_t                     rd_cell;

  connect4_win_scan u_scan (
    .board   (board),
    .col     (scan_col),
    .row     (scan_row),
    .red_hit (red_hit),
    .yel_hit (yel_hit)
  );

  always_comb begin
    col_ok = {1'b0, bus.move_col} < (CW+1)'(COLS);
    sel_h  = col_ok ? height[bus.move_col] : '0;
    if (!col_ok)           bad = 1'b1;
    else if (bus.move_pop) bad = (sel_h == '0) || (board[bus.move_col][0].color != player);
    else                   bad = (sel_h == HW'(ROWS));
    all_full = 1'b1;
    for (int c = 0; c < COLS; c++)
      if (height[c] != HW'(ROWS)) all_full = 1'b0;
    scan_last = (scan_col == CW'(COLS-1)) && (scan_row == RW'(ROWS-1));
    mover_win = player ? win_red : win_yel;
    opp_win   = player ? win_yel : win_red;
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    bus.move_ack = 1'b0;
    bus.busy     = 1'b1;
    accept       = 1'b0;
    case (state)
      S_IDLE: begin
        bus.busy = 1'b0;
        if (bus.move_req && !bad) begin
          accept = 1'b1;
          if (!bus.move_pop)        state_nxt = S_DROP;
          else if (sel_h == HW'(1)) state_nxt = S_CLRTOP;
          else                      state_nxt = S_SHIFT;
        end
      end
      S_DROP: begin
        bus.move_ack = 1'b1;
        state_nxt    = S_SCAN;
      end
      S_SHIFT:   if (sh_row == height[cur_col] - HW'(2)) state_nxt = S_CLRTOP;
      S_CLRTOP: begin
        bus.move_ack = 1'b1;
        state_nxt    = S_SCAN;
      end
      S_SCAN:    if (scan_last) state_nxt = S_RESOLVE;
      S_RESOLVE: state_nxt = (mover_win || opp_win || all_full) ? S_OVER : S_IDLE;
      S_OVER:    bus.busy = 1'b0;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      board        <= '0;
      for (int c = 0; c < COLS; c++) height[c] <= '0;
      player       <= PLAYER_RED;
      cur_col      <= '0;
      sh_row       <= '0;
      scan_col     <= '0;
      scan_row     <= '0;
      win_red      <= 1'b0;
      win_yel      <= 1'b0;
      move_err     <= 1'b0;
      winner_valid <= 1'b0;
      winner       <= 1'b0;
      draw         <= 1'b0;
    end else begin
      move_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.move_req && bad) move_err <= 1'b1;
          if (accept) begin
            cur_col  <= bus.move_col;
            sh_row   <= '0;
            scan_col <= '0;
            scan_row <= '0;
            win_red  <= 1'b0;
            win_yel  <= 1'b0;
          end
        end
        S_DROP: begin
          board[cur_col][height[cur_col][RW-1:0]] <= cell_t'{occ: 1'b1, color: player};
          height[cur_col] <= height[cur_col] + 1'b1;
        end
        S_SHIFT: begin
          board[cur_col][sh_row[RW-1:0]] <= board[cur_col][sh_row[RW-1:0] + 1'b1];
          sh_row <= sh_row + 1'b1;
        end
        S_CLRTOP: begin
          board[cur_col][height[cur_col][RW-1:0] - 1'b1] <= '0;
          height[cur_col] <= height[cur_col] - 1'b1;
        end
        S_SCAN: begin
          win_red <= win_red | red_hit;
          win_yel <= win_yel | yel_hit;
          // col-major walk: rows of a column first
          if (scan_row == RW'(ROWS-1)) begin
            scan_row <= '0;
            scan_col <= scan_col + 1'b1;
          end else begin
            scan_row <= scan_row + 1'b1;
          end
        end
        S_RESOLVE: begin
          if (mover_win) begin
            winner_valid <= 1'b1;
            winner       <= player;
          end else if (opp_win) begin
            winner_valid <= 1'b1;
            winner       <= ~player;
          end else if (all_full) begin
            draw <= 1'b1;
          end else begin
            player <= ~player;
          end
        end
        S_OVER:  if (bus.move_req) move_err <= 1'b1;
        default: ;
      endcase
    end
  end

`ifdef SCORE_EN
  logic [SCORE_W-1:0] score_red, score_yel;
  logic               win_color;

  assign win_color = mover_win ? player : ~player;

  always_ff @(posedge clock) begin
    if (bus.reset_score) begin
      score_red <= '0;
      score_yel <= '0;
    end else if (!reset && state == S_RESOLVE && (mover_win || opp_win)) begin
      if (win_color == PLAYER_RED) begin
        if (score_red != '1) score_red <= score_red + 1'b1;
      end else begin
        if (score_yel != '1) score_yel <= score_yel + 1'b1;
      end
    end
  end

  assign bus.score_red = score_red;
  assign bus.score_yel = score_yel;
`else
  logic unused_reset_score;
  assign unused_reset_score = bus.reset_score;
  assign bus.score_red      = '0;
  assign bus.score_yel      = '0;
`endif

  always_comb begin
    rd_cell = '0;
    if ({1'b0, bus.rd_col} < (CW+1)'(COLS) && {1'b0, bus.rd_row} < (RW+1)'(ROWS))
      rd_cell = board[bus.rd_col][bus.rd_row];
  end

  assign bus.rd_occupied  = rd_cell.occ;
  assign bus.rd_color     = rd_cell.color;
  assign bus.move_err     = move_err;
  assign bus.player       = player;
  assign bus.game_over    = (state == S_OVER);
  assign bus.winner_valid = winner_valid;
  assign bus.winner       = winner;
  assign bus.draw         = draw;
endmodule
